// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: operands+opcode toward the ALU, result+err back.
interface alu_seq_if #(parameter int N = 8);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out;
    logic             err;

    modport master (
        output in_valid, a, b, opcode, out_ready,
        input  in_ready, out_valid, out, err
    );

    modport slave (
        input  in_valid, a, b, opcode, out_ready,
        output in_ready, out_valid, out, err
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential signed ALU: logic/add/sub in 1 cycle, mul/div iterative over N CALC cycles (latency N+1).
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_seq #(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(N);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   out_q, out_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [N-1:0]   araw_q, araw_d;
    logic           neg_q, neg_d;
    logic           sa_q, sa_d;
    logic           bz_q, bz_d;
    logic           err_q, err_d;

    logic [N-1:0]   a_mag, b_mag, quo, rem;
    logic [W-1:0]   a_ext, b_ext, sh;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.err       = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        opa_d   = opa_q;
        acc_d   = acc_q;
        out_d   = out_q;
        opb_d   = opb_q;
        araw_d  = araw_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        bz_d    = bz_q;
        err_d   = err_q;
        quo     = '0;
        rem     = '0;
        sh      = '0;
        a_mag   = bus.a[N-1] ? (~bus.a + 1'b1) : bus.a;
        b_mag   = bus.b[N-1] ? (~bus.b + 1'b1) : bus.b;
        a_ext   = {{N{bus.a[N-1]}}, bus.a};
        b_ext   = {{N{bus.b[N-1]}}, bus.b};

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Mul/div run on magnitudes; signs are reapplied on the last step.
                    op_d    = bus.opcode;
                    sa_d    = bus.a[N-1];
                    neg_d   = bus.a[N-1] ^ bus.b[N-1];
                    bz_d    = (bus.b == '0);
                    araw_d  = bus.a;
                    opb_d   = b_mag;
                    opa_d   = {{N{1'b0}}, a_mag};
                    acc_d   = (bus.opcode == OP_DIV) ? {{N{1'b0}}, a_mag} : '0;
                    cnt_d   = '0;
                    state_d = DONE;
                    err_d   = 1'b0;
                    case (bus.opcode)
                        OP_ADD: out_d = a_ext + b_ext;
                        OP_SUB: out_d = a_ext - b_ext;
                        OP_AND: out_d = a_ext & b_ext;
                        OP_OR:  out_d = a_ext | b_ext;
                        OP_XOR: out_d = a_ext ^ b_ext;
                        OP_MUL, OP_DIV: begin
                            state_d = CALC;
                            err_d   = err_q;
                        end
                        default: begin
                            out_d = '0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = acc_q + (opb_q[0] ? opa_q : '0);
                    opa_d = {opa_q[W-2:0], 1'b0};
                    opb_d = {1'b0, opb_q[N-1:1]};
                end else begin
                    // Restoring division: acc = {partial remainder, dividend/quotient}.
                    sh = {acc_q[W-2:0], 1'b0};
                    if (sh[W-1:N] >= opb_q) begin
                        sh[W-1:N] = sh[W-1:N] - opb_q;
                        sh[0]     = 1'b1;
                    end
                    acc_d = sh;
                end
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (op_q == OP_MUL) begin
                        out_d = neg_q ? (~acc_d + 1'b1) : acc_d;
                        err_d = 1'b0;
                    end else if (bz_q) begin
                        out_d = {araw_q, {N{1'b1}}};
                        err_d = 1'b1;
                    end else begin
                        quo   = neg_q ? (~acc_d[N-1:0] + 1'b1) : acc_d[N-1:0];
                        rem   = sa_q ? (~acc_d[W-1:N] + 1'b1) : acc_d[W-1:N];
                        out_d = {rem, quo};
                        err_d = 1'b0;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            opa_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            opb_q   <= '0;
            araw_q  <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            bz_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            opb_q   <= opb_d;
            araw_q  <= araw_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            bz_q    <= bz_d;
            err_q   <= err_d;
        end
    end
endmodule
